// File: rtl/aes_tb_pkg.sv
// aes_tb_pkg: widths, default timeout and checker state shared by the AES vector generator and checker
package aes_tb_pkg;
  localparam int DATA_W  = 128;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 399;
  typedef enum logic {IDLE, WAIT} chk_state_e;
endpackage

// File: rtl/aes_result_checker_rise_detect.sv
// rise_detect: registered rising-edge detector with synchronous reset
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);
  logic sig_q;
  always_ff @(posedge clk) sig_q <= reset ? 1'b0 : sig;
  assign rise = sig & ~sig_q;
endmodule

// File: rtl/aes_result_checker.sv
// aes_result_checker: compares AES core output to expected ciphertext, measures latency, keeps statistics
module aes_result_checker #(
  parameter int DATA_W  = aes_tb_pkg::DATA_W,
  parameter int CNT_W   = aes_tb_pkg::CNT_W,
  parameter int TIMEOUT = aes_tb_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic [DATA_W-1:0] expected_in,
  input  logic              ct_valid,
  input  logic [DATA_W-1:0] ct_in,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              overrun,
  output logic [CNT_W-1:0]  latency,
  output logic [DATA_W-1:0] last_ct,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              sticky_error
);
  import aes_tb_pkg::*;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  chk_state_e        state;
  logic              rise;
  logic              match;
  logic              tmo_hit;
  logic [DATA_W-1:0] exp_q;
  logic [CNT_W-1:0]  lat_cnt;
  logic [CNT_W-1:0]  pass_inc;
  logic [CNT_W-1:0]  fail_inc;
  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .sig   (trig),
    .rise  (rise)
  );
  assign busy     = (state == WAIT);
  assign match    = (ct_in == exp_q);
  assign tmo_hit  = (lat_cnt == TMO);
  assign pass_inc = pass_count + {{(CNT_W-1){1'b0}}, ~&pass_count};
  assign fail_inc = fail_count + {{(CNT_W-1){1'b0}}, ~&fail_count};
  // lat_cnt holds the index of the current cycle since the trigger edge, so it is 1 in the first WAIT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      exp_q        <= '0;
      lat_cnt      <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
      latency      <= '0;
      last_ct      <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      sticky_error <= 1'b0;
    end else begin
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
      overrun <= 1'b0;
      if (state == IDLE) begin
        if (ct_valid) sticky_error <= 1'b1;
        if (rise) begin
          exp_q   <= expected_in;
          lat_cnt <= CNT_W'(1);
          state   <= WAIT;
        end
      end else begin
        if (ct_valid) begin
          last_ct <= ct_in;
          latency <= lat_cnt;
          if (match) begin
            pass       <= 1'b1;
            pass_count <= pass_inc;
          end else begin
            fail         <= 1'b1;
            fail_count   <= fail_inc;
            sticky_error <= 1'b1;
          end
        end else if (rise || tmo_hit) begin
          fail         <= 1'b1;
          overrun      <= rise;
          timeout      <= ~rise;
          fail_count   <= fail_inc;
          sticky_error <= 1'b1;
          if (!rise) latency <= TMO;
        end
        if (rise) begin
          exp_q   <= expected_in;
          lat_cnt <= CNT_W'(1);
        end else if (ct_valid || tmo_hit) begin
          state <= IDLE;
        end else begin
          lat_cnt <= lat_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_result_checker.sv
// tb_aes_result_checker: directed and random checks of aes_result_checker against a cycle-time reference model
module tb_aes_result_checker;
  localparam int DW = 128;
  localparam int CW = 16;
  localparam int TO = 399;
  localparam logic [DW-1:0] K1 = 128'h3925841D02DC09FBDC118597196A0B32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, trig, cv;
  logic [DW-1:0] exp_in, ct;
  logic busy, pass, fail, timeout, overrun, sticky_error;
  logic [CW-1:0] latency, pass_count, fail_count;
  logic [DW-1:0] last_ct;
  logic s_trig, s_cv;
  logic [DW-1:0] s_exp, s_ct;
  logic s_busy, s_pass, s_fail, s_timeout, s_overrun, s_sticky;
  logic [3:0] s_latency, s_pc, s_fc;
  logic [DW-1:0] s_last;
  int total = 0;
  int bad = 0;
  aes_result_checker dut (
    .clk(clk), .reset(reset), .trig(trig), .expected_in(exp_in), .ct_valid(cv), .ct_in(ct),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout), .overrun(overrun),
    .latency(latency), .last_ct(last_ct), .pass_count(pass_count), .fail_count(fail_count),
    .sticky_error(sticky_error)
  );
  aes_result_checker #(.DATA_W(DW), .CNT_W(4), .TIMEOUT(10)) dut_s (
    .clk(clk), .reset(reset), .trig(s_trig), .expected_in(s_exp), .ct_valid(s_cv), .ct_in(s_ct),
    .busy(s_busy), .pass(s_pass), .fail(s_fail), .timeout(s_timeout), .overrun(s_overrun),
    .latency(s_latency), .last_ct(s_last), .pass_count(s_pc), .fail_count(s_fc),
    .sticky_error(s_sticky)
  );
  // reference model: a vector is outstanding since absolute cycle m_start
  bit m_wait, m_prev;
  int m_start, cyc;
  logic [DW-1:0] m_exp;
  bit e_busy, e_pass, e_fail, e_to, e_ov, e_sticky;
  int e_lat, e_pc, e_fc;
  logic [DW-1:0] e_last;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, want);
    end
  endtask
  task automatic check_all();
    chk("busy", DW'(busy), DW'(e_busy));
    chk("pass", DW'(pass), DW'(e_pass));
    chk("fail", DW'(fail), DW'(e_fail));
    chk("timeout", DW'(timeout), DW'(e_to));
    chk("overrun", DW'(overrun), DW'(e_ov));
    chk("latency", DW'(latency), DW'(e_lat));
    chk("last_ct", last_ct, e_last);
    chk("pass_count", DW'(pass_count), DW'(e_pc));
    chk("fail_count", DW'(fail_count), DW'(e_fc));
    chk("sticky", DW'(sticky_error), DW'(e_sticky));
  endtask
  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction
  task automatic do_reset();
    reset = 1'b1; trig = 1'b0; cv = 1'b0; exp_in = '0; ct = '0;
    s_trig = 1'b0; s_cv = 1'b0; s_exp = '0; s_ct = '0;
    m_wait = 0; m_prev = 0;
    {e_busy, e_pass, e_fail, e_to, e_ov, e_sticky} = '0;
    e_lat = 0; e_pc = 0; e_fc = 0; e_last = '0;
    @(posedge clk); @(posedge clk); #1;
    check_all();
    reset = 1'b0;
  endtask
  task automatic step(input bit t, input logic [DW-1:0] e, input bit v, input logic [DW-1:0] c);
    bit r;
    int age;
    trig = t; exp_in = e; cv = v; ct = c;
    r = t && !m_prev;
    m_prev = t;
    {e_pass, e_fail, e_to, e_ov} = '0;
    if (m_wait) begin
      age = cyc - m_start;
      if (v) begin
        e_lat = age; e_last = c;
        if (c == m_exp) begin e_pass = 1; e_pc = sat(e_pc); end
        else begin e_fail = 1; e_fc = sat(e_fc); e_sticky = 1; end
      end else if (r) begin
        e_fail = 1; e_ov = 1; e_fc = sat(e_fc); e_sticky = 1;
      end else if (age == TO) begin
        e_fail = 1; e_to = 1; e_lat = TO; e_fc = sat(e_fc); e_sticky = 1;
      end
      if (r) begin m_start = cyc; m_exp = e; end
      else if (v || age == TO) m_wait = 0;
    end else begin
      if (v) e_sticky = 1;
      if (r) begin m_wait = 1; m_start = cyc; m_exp = e; end
    end
    e_busy = m_wait;
    @(posedge clk); #1;
    cyc++;
    check_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0);
  endtask
  initial begin
    cyc = 0;
    do_reset();
    step(1, K1, 0, '0); idle(19); step(0, '0, 1, K1);
    chk("t1_pass", DW'(pass), DW'(1)); chk("t1_lat", DW'(latency), DW'(20));
    chk("t1_pc", DW'(pass_count), DW'(1)); chk("t1_sticky", DW'(sticky_error), DW'(0));
    do_reset();
    step(1, K1, 0, '0); idle(19); step(0, '0, 1, K1 ^ 128'd1);
    chk("t2_fail", DW'(fail), DW'(1)); chk("t2_fc", DW'(fail_count), DW'(1));
    chk("t2_sticky", DW'(sticky_error), DW'(1)); chk("t2_last", last_ct, K1 ^ 128'd1);
    do_reset();
    step(1, K1, 0, '0); idle(399);
    chk("t3_to", DW'(timeout & fail), DW'(1)); chk("t3_lat", DW'(latency), DW'(399));
    chk("t3_busy", DW'(busy), DW'(0)); chk("t3_fc", DW'(fail_count), DW'(1));
    do_reset();
    step(1, K1, 0, '0); idle(398); step(0, '0, 1, K1);
    chk("t4_pass", DW'(pass), DW'(1)); chk("t4_to", DW'(timeout), DW'(0));
    chk("t4_lat", DW'(latency), DW'(399));
    do_reset();
    step(1, K1, 0, '0); idle(9); step(1, ~K1, 0, '0);
    chk("t5_ov", DW'(overrun & fail), DW'(1)); chk("t5_busy", DW'(busy), DW'(1));
    idle(14); step(0, '0, 1, ~K1);
    chk("t5_pass", DW'(pass), DW'(1)); chk("t5_lat", DW'(latency), DW'(15));
    step(0, '0, 1, K1);
    chk("t6_sticky", DW'(sticky_error), DW'(1)); chk("t6_pc", DW'(pass_count), DW'(1));
    step(1, K1, 0, '0); idle(5); step(1, 128'h55, 1, K1); idle(3); step(0, '0, 1, 128'h55);
    chk("both_lat", DW'(latency), DW'(4));
    step(1, K1, 0, '0); idle(5);
    do_reset();
    chk("abort_fc", DW'(fail_count), DW'(0));
    for (int i = 0; i < 4000; i++) begin
      bit t, v;
      logic [DW-1:0] e, c;
      t = ($urandom_range(0, 15) == 0) ? ~trig : trig;
      v = ($urandom_range(0, 24) == 0);
      e = {$urandom, $urandom, $urandom, $urandom};
      c = $urandom_range(0, 1) ? m_exp : e;
      step(t, e, v, c);
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_trig = 1'b1; s_exp = K1; s_cv = 1'b0; idle(1);
      s_trig = 1'b0; s_cv = 1'b1; s_ct = K1; idle(1);
      s_cv = 1'b0;
      chk("sat_pulse", DW'(s_pass), DW'(1));
    end
    chk("sat_pc", DW'(s_pc), DW'(4'hF));
    for (int i = 0; i < 20; i++) begin
      s_trig = 1'b1; idle(1);
      s_trig = 1'b0; idle(1);
    end
    chk("sat_fc", DW'(s_fc), DW'(4'hF));
    chk("sat_pc_hold", DW'(s_pc), DW'(4'hF));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_result_checker.md
Name: aes_result_checker

Overview:
- Consumer-side companion to the AES stimulus generator. Sits at the AES core output.
- On each trigger edge from the vector source, latches the expected ciphertext supplied with it.
- Waits for the core's ciphertext-valid strobe, compares the result and measures encryption latency in clock cycles.
- Reports pass/fail/timeout pulses and saturating statistics for on-board or bench monitoring.

Parameters:
- DATA_W, 128, ciphertext/expected width in bits
- CNT_W, 16, width of latency and statistics counters
- TIMEOUT, 399, cycles after trigger edge with no valid result before a timeout is declared (1..2^CNT_W-1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trig  in  1  vector-start level from stimulus source; only its rising edge is used
- expected_in  in  DATA_W  expected ciphertext; valid in the trig rising-edge cycle
- ct_valid  in  1  AES core result strobe, single cycle
- ct_in  in  DATA_W  AES core ciphertext, valid with ct_valid
- busy  out  1  high while waiting for a result
- pass  out  1  one-cycle pulse: result matched
- fail  out  1  one-cycle pulse: mismatch, timeout or overrun
- timeout  out  1  one-cycle pulse, coincident with fail, for a timeout
- overrun  out  1  one-cycle pulse, coincident with fail, for a new trigger before a result
- latency  out  CNT_W  cycles from trigger edge to ct_valid for the last completed vector
- last_ct  out  DATA_W  last ciphertext captured
- pass_count  out  CNT_W  number of passes, saturating
- fail_count  out  CNT_W  number of fails of any kind, saturating
- sticky_error  out  1  set on any fail or spurious ct_valid; cleared only by reset

Behaviour:
- Reset: all outputs 0, including counters, last_ct and latency. State goes to IDLE. trig_q is cleared to 0.
- Reset mid-WAIT aborts silently: no pulse, no count.
- Edge detect: rise = trig & ~trig_q, where trig_q is trig registered. If trig is already high in the first cycle after reset, a rise is seen.
- Status pulses are registered and appear the cycle after the qualifying event. Latency is 1 cycle.

State machine states: IDLE, WAIT.
- IDLE, rise: latch expected_in, clear lat_cnt to 0, go to WAIT, busy=1.
- IDLE, ct_valid: spurious. Set sticky_error. No pulse, no count, last_ct unchanged.
- WAIT, each cycle: lat_cnt increments. The rise cycle is cycle 0.
- WAIT, ct_valid: capture ct_in into last_ct and lat_cnt into latency. Compare all DATA_W bits. Match gives pass and pass_count+1. Mismatch gives fail, fail_count+1 and sticky_error. Go to IDLE.
- WAIT, lat_cnt == TIMEOUT with no ct_valid: fail+timeout pulses, latency = TIMEOUT, last_ct unchanged, go to IDLE.

Simultaneous events:
- WAIT, ct_valid and TIMEOUT reached together: ct_valid wins. The result is compared and no timeout is raised.
- WAIT, ct_valid and rise together: complete the current comparison normally. In the same cycle, latch the new expected_in, clear lat_cnt and stay in WAIT.
- WAIT, rise without ct_valid: overrun. Raise fail+overrun pulses, fail_count+1, sticky_error. Relatch expected_in, clear lat_cnt, stay in WAIT.

Arithmetic:
- Counters saturate at all-ones and never wrap.
- lat_cnt cannot exceed TIMEOUT.

Decomposition:
- Package aes_tb_pkg: DATA_W, CNT_W, default TIMEOUT, and the checker state enum (IDLE, WAIT), shared with the stimulus generator.
- One sub-module, rise_detect: a registered rising-edge detector with synchronous reset, reusable for other trigger inputs.

Test Plan:
1. Reset, then trig rise with expected_in=128'h3925841D02DC09FBDC118597196A0B32, then ct_valid with the same ct_in 20 cycles later -> pass pulse at cycle 21, latency=20, pass_count=1, sticky_error=0.
2. Same as 1 but ct_in differs in bit 0 -> fail pulse, fail_count=1, sticky_error=1, last_ct equals the wrong value.
3. trig rise with no ct_valid -> at lat_cnt=399, fail+timeout pulses the next cycle, latency=399, busy drops, fail_count=1.
4. ct_valid on the same cycle lat_cnt reaches 399 with matching data -> pass only, no timeout, latency=399.
5. Second trig rise 10 cycles after the first with no result -> fail+overrun pulse, still busy. Correct ct_valid 15 cycles later -> pass, latency=15.
6. ct_valid pulse while IDLE -> sticky_error=1, counters unchanged. Force pass_count to 16'hFFFF with one more match -> remains 16'hFFFF.
